// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue: epoch-tagged circular fetch queue between pc_gen/I-cache
// and the backend FE queue. Holds fetch after an accepted exception entry
// until the next flush. Optional zero-latency empty-queue bypass is compiled
// in with BP_FE_FETCH_QUEUE_BYPASS_EN.
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = 8,
  parameter int epoch_width_p = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_v_i,
  output logic                       enq_ready_o,
  input  logic [vaddr_width_p-1:0]   enq_pc_i,
  input  logic [instr_width_p-1:0]   enq_instr_i,
  input  logic                       enq_exc_i,
  input  logic [epoch_width_p-1:0]   enq_epoch_i,
  input  logic                       flush_i,
  output logic [epoch_width_p-1:0]   epoch_o,
  output logic                       deq_v_o,
  input  logic                       deq_ready_i,
  output logic [vaddr_width_p-1:0]   deq_pc_o,
  output logic [instr_width_p-1:0]   deq_instr_o,
  output logic                       deq_exc_o,
  output logic [$clog2(els_p):0]     count_o,
  output logic [7:0]                 drop_count_o
);

  localparam int ptr_w   = $clog2(els_p);
  localparam int cnt_w   = ptr_w + 1;
  localparam int entry_w = vaddr_width_p + instr_width_p + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [entry_w-1:0]       r_mem [els_p];
  logic [ptr_w-1:0]         r_wptr, r_rptr;
  logic [cnt_w-1:0]         r_count;
  logic [epoch_width_p-1:0] r_epoch;
  logic [0:0]               r_state;
  logic [7:0]               r_drop;

  logic                     w_enq_ready, w_cur_epoch, w_enq_fire;
  logic                     w_enq_acc, w_enq_drop, w_nonempty;
  logic                     w_byp, w_byp_fire, w_write, w_pop;
  logic [cnt_w-1:0]         w_count_nxt;
  logic [entry_w-1:0]       w_head, w_enq_entry;

  assign w_enq_ready = (r_state == ST_RUN) && (r_count < cnt_w'(els_p));
  assign w_cur_epoch = (enq_epoch_i == r_epoch);
  assign w_enq_fire  = enq_v_i && w_enq_ready && !flush_i;
  assign w_enq_acc   = w_enq_fire && w_cur_epoch;
  assign w_enq_drop  = w_enq_fire && !w_cur_epoch;
  assign w_nonempty  = (r_count != '0);

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  // Empty queue in RUN with no flush: present the incoming entry directly.
  assign w_byp = enq_v_i && !w_nonempty && (r_state == ST_RUN) && !flush_i && w_cur_epoch;
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_fire  = w_byp && deq_ready_i;
  assign w_write     = w_enq_acc && !w_byp_fire;
  assign w_pop       = w_nonempty && !flush_i && deq_ready_i;
  assign w_enq_entry = {enq_pc_i, enq_instr_i, enq_exc_i};
  assign w_head      = w_byp ? w_enq_entry : r_mem[r_rptr];

  assign enq_ready_o  = w_enq_ready;
  assign deq_v_o      = (w_nonempty && !flush_i) || w_byp;
  assign deq_pc_o     = w_head[entry_w-1 -: vaddr_width_p];
  assign deq_instr_o  = w_head[instr_width_p:1];
  assign deq_exc_o    = w_head[0];
  assign epoch_o      = r_epoch;
  assign count_o      = r_count;
  assign drop_count_o = r_drop;

  // Occupancy next value from independent write/pop events.
  always_comb begin
    w_count_nxt = r_count;
    if (w_write && !w_pop)
      w_count_nxt = r_count + cnt_w'(1);
    else if (!w_write && w_pop)
      w_count_nxt = r_count - cnt_w'(1);
  end

  // Entry storage; not reset.
  always_ff @(posedge clk_i) begin
    if (w_write)
      r_mem[r_wptr] <= w_enq_entry;
  end

  // Pointers, occupancy, epoch, hold state and drop counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_epoch <= '0;
      r_state <= ST_RUN;
      r_drop  <= '0;
    end else if (flush_i) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
      r_epoch <= r_epoch + epoch_width_p'(1);
      r_state <= ST_RUN;
    end else begin
      if (w_write) r_wptr <= r_wptr + ptr_w'(1);
      if (w_pop)   r_rptr <= r_rptr + ptr_w'(1);
      r_count <= w_count_nxt;
      // Bypassed exception entries also hold fetch.
      if (w_enq_acc && enq_exc_i) r_state <= ST_HOLD;
      if (w_enq_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

endmodule
